p_div_pow2_reg: RTL and testbench
=================================

// Module: p_div_pow2_reg
// PURPOSE
//  Registered divide-by-2^SHIFT for perceptron datapaths (INT or FXP), with selectable rounding.
//  Realigns input fixed-point format to output format; saturates/wraps to output precision.
//  Sits after accumulators and before activation and requantisation stages.
//  Ports are one-cycle registered.
// PARAMETERS
//  SHIFT    2           divide exponent (>=1); result = in / 2^SHIFT
//  CARRYUP  1           0: floor (discard); 1: +1 if discarded bits >= half LSB; 2: +1 if discarded bits != 0
//  I_CONF   INT,1,8,0   dconf_t {dtype, sign, prec, frac} of in
//  O_CONF   INT,1,8,0   dconf_t of out; dtype must equal I_CONF.dtype; INT forces frac=0
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  reset      in   1            synchronous, active-high
//  in_valid   in   1            sample in this cycle
//  in         in   I_CONF.prec  operand; two's complement if I_CONF.sign else unsigned
//  out_valid  out  1            out/rem/sat valid (registered in_valid)
//  rem        out  SHIFT        raw in[SHIFT-1:0] of sampled operand
//  out        out  O_CONF.prec  rounded quotient in O_CONF format
//  sat        out  1            result clipped (always 0 without P_DIV_POW2_SAT_EN)
// BEHAVIOUR
//  - Latency 1: on clk with in_valid=1, register out/rem/sat; out_valid<=in_valid every cycle.
//  - With in_valid=0: out/rem/sat hold last value; out_valid drops to 0.
//  - No backpressure; one result per cycle accepted.
//  - reset=1 at clk: out_valid, out, rem, sat <= 0; overrides in_valid in same cycle.
//  - Extension: sign-extend if I_CONF.sign, else zero-extend, to W = I_PREC+|O_FRAC-I_FRAC|+2.
//  - Effective shift E = SHIFT + I_FRAC - O_FRAC.
//  - E<=0: left shift by -E, no rounding.
//  - E>0: q = ext >>> E (arithmetic/floor).
//  - E>0: d = the E discarded bits, unsigned.
//  - Rounding mode 1: q += (d >= 2^(E-1)).
//  - Rounding mode 2: q += (d != 0).
//  - Rounding mode 0: q unchanged.
//  - Negative values round toward +inf on ties (-2/4 mode1 -> 0).
//  - Range check on widened q against O_CONF range:
//    signed [-2^(OP-1), 2^(OP-1)-1]; unsigned [0, 2^OP-1].
//  - Unsigned output with negative q counts as out of range.
//  - rem is independent of rounding mode and frac alignment.
//  - Parameter errors (SHIFT<1, dtype mismatch, CARRYUP>2) -> $error at elaboration.
// CONFIGURATION
//  P_DIV_POW2_SAT_EN defined:
//   out-of-range q clamps to nearest bound; sat=1 for that result.
//  P_DIV_POW2_SAT_EN undefined:
//   out = q[OP-1:0] (wrap); sat tied to 0; no compare logic.
// TESTING (INT, signed 8b in/out, SHIFT=2 unless noted)
//  - CARRYUP=1: in=3 -> out=1, rem=3, out_valid=1 one cycle later.
//  - CARRYUP=1: in=-2 -> out=0, rem=2.
//  - CARRYUP=0: in=-2 -> out=-1 (8'hFF).
//  - CARRYUP=2: in=5 -> out=2, rem=1.
//  - CARRYUP=1: in=5 -> out=1, rem=1.
//  - O_PREC=4, CARRYUP=0, in=127: SAT_EN -> out=4'h7, sat=1; no SAT_EN -> out=4'hF, sat=0.
//  - FXP I_FRAC=3, O_FRAC=3, CARRYUP=1: in=8'b00011_100 (3.5) -> out=8'b00000_111 (0.875).
//  - reset asserted with in_valid=1 -> next cycle out_valid=0, out=0, rem=0.
//  - reset deasserted -> next accepted sample correct.
//  - 1000 random in with random in_valid, all CARRYUP modes vs integer reference model.
//  - Reference: floor(in/4) plus mode rule, then clamp/wrap.

Source files
------------

// File: rtl/p_div_pow2_reg.sv
// p_div_pow2_reg
//   Registered divide-by-2^SHIFT for perceptron datapaths (INT or FXP).
//   The operand is realigned from the input fixed-point format to the output
//   format, then rounded according to CARRYUP. Finally it is either saturated
//   or wrapped to the output precision. Latency is one clock.
//
//   Optional feature macro: P_DIV_POW2_SAT_EN
//     defined   : out-of-range results clamp to the nearest bound, sat=1
//     undefined : out keeps the low O_PREC bits (wrap), sat tied to 0
//
//   Parameters (the I_* / O_* groups are the dconf_t fields {dtype, sign, prec, frac}):
//     SHIFT    divide exponent (>=1)
//     CARRYUP  0 floor, 1 round half up, 2 round up if any discarded bit set
//     *_DTYPE  0 = INT (frac forced to 0), 1 = FXP
//     *_SIGN   1 = two's complement, 0 = unsigned
//     *_PREC   bit width
//     *_FRAC   fractional bits
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high
//     in_valid   sample in this cycle
//     in         operand, I_PREC bits
//     out_valid  registered in_valid
//     rem        raw low SHIFT bits of the sampled operand
//     out        rounded quotient, O_PREC bits
//     sat        result was clipped
module p_div_pow2_reg #(
  parameter int SHIFT   = 2,
  parameter int CARRYUP = 1,
  parameter int I_DTYPE = 0,
  parameter int I_SIGN  = 1,
  parameter int I_PREC  = 8,
  parameter int I_FRAC  = 0,
  parameter int O_DTYPE = 0,
  parameter int O_SIGN  = 1,
  parameter int O_PREC  = 8,
  parameter int O_FRAC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [I_PREC-1:0] in,
  output logic              out_valid,
  output logic [SHIFT-1:0]  rem,
  output logic [O_PREC-1:0] out,
  output logic              sat
);

  localparam int IFR   = (I_DTYPE == 0) ? 0 : I_FRAC;
  localparam int OFR   = (O_DTYPE == 0) ? 0 : O_FRAC;
  localparam int FDIFF = (OFR > IFR) ? (OFR - IFR) : (IFR - OFR);
  localparam int W     = I_PREC + FDIFF + 2;
  localparam int E     = SHIFT + IFR - OFR;
  localparam int EPOS  = (E > 0) ? E : 0;

  // The working width covers the realigned operand, the full output range
  // plus a sign bit, and every discarded bit. The +1 headroom keeps the
  // rounding increment and the range compare free of overflow.
  localparam int QW0 = (W > O_PREC + 1) ? W : (O_PREC + 1);
  localparam int QW  = ((QW0 > EPOS + 1) ? QW0 : (EPOS + 1)) + 1;
  localparam logic [QW-1:0] ONE = QW'(1);

  generate
    if (SHIFT < 1) begin : g_err_shift
      $error("p_div_pow2_reg: SHIFT must be >= 1");
    end
    if (I_DTYPE != O_DTYPE) begin : g_err_dtype
      $error("p_div_pow2_reg: I_DTYPE and O_DTYPE must match");
    end
    if (CARRYUP < 0 || CARRYUP > 2) begin : g_err_carry
      $error("p_div_pow2_reg: CARRYUP must be 0, 1 or 2");
    end
  endgenerate

  logic signed [QW-1:0] ext;
  logic signed [QW-1:0] q;
  logic [O_PREC-1:0]    res;
  logic                 sat_d;
  logic [SHIFT-1:0]     rem_d;

  always_comb begin
    ext = '0;
    if (I_SIGN != 0) ext = {{(QW-I_PREC){in[I_PREC-1]}}, in};
    else             ext = {{(QW-I_PREC){1'b0}}, in};
  end

  generate
    if (SHIFT <= I_PREC) begin : g_rem_slice
      assign rem_d = in[SHIFT-1:0];
    end else begin : g_rem_pad
      assign rem_d = {{(SHIFT-I_PREC){1'b0}}, in};
    end
  endgenerate

  generate
    if (E > 0) begin : g_rshift
      localparam logic [QW-1:0] MASK = (ONE << E) - ONE;
      localparam logic [QW-1:0] HALF = ONE << (E - 1);
      logic [QW-1:0]        d;
      logic                 up;
      logic signed [QW-1:0] fl;
      // The floor is computed on its own so the arithmetic shift is never
      // demoted to a logical shift by mixing with unsigned operands. Because
      // the floor is taken first, negative ties round toward +inf.
      always_comb begin
        fl = ext >>> E;
        d  = ext & MASK;
        up = 1'b0;
        if (CARRYUP == 1)      up = (d >= HALF);
        else if (CARRYUP == 2) up = (d != '0);
        q = fl + $signed({{(QW-1){1'b0}}, up});
      end
    end else begin : g_lshift
      localparam int LS = -E;
      always_comb begin
        q = ext <<< LS;
      end
    end
  endgenerate

`ifdef P_DIV_POW2_SAT_EN
  localparam logic signed [QW-1:0] HI = (O_SIGN != 0) ? ((ONE << (O_PREC - 1)) - ONE)
                                                      : ((ONE << O_PREC) - ONE);
  localparam logic signed [QW-1:0] LO = (O_SIGN != 0) ? -(ONE << (O_PREC - 1)) : '0;

  // A negative q against an unsigned output falls below LO (= 0) and clamps to 0.
  always_comb begin
    res   = q[O_PREC-1:0];
    sat_d = 1'b0;
    if (q > HI) begin
      res   = HI[O_PREC-1:0];
      sat_d = 1'b1;
    end else if (q < LO) begin
      res   = LO[O_PREC-1:0];
      sat_d = 1'b1;
    end
  end
`else
  logic q_unused;
  assign q_unused = ^q[QW-1:O_PREC];

  always_comb begin
    res   = q[O_PREC-1:0];
    sat_d = 1'b0;
  end
`endif

  // The result registers only load on accepted samples, so they hold between
  // samples. out_valid follows in_valid on every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      rem       <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= res;
        rem <= rem_d;
        sat <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_p_div_pow2_reg.sv
// tb_p_div_pow2_reg
//   Drives one shared 8-bit stimulus into five p_div_pow2_reg instances
//   (SHIFT=2): signed INT with CARRYUP 0/1/2, signed INT with a 4-bit output,
//   and signed FXP with I_FRAC=O_FRAC=3. Directed vectors come first,
//   followed by random samples checked against an integer reference model.
module tb_p_div_pow2_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] din = 8'h00;

  logic       ov0, ov1, ov2, ov4, ovf;
  logic [1:0] rem0, rem1, rem2, rem4, remf;
  logic [7:0] out0, out1, out2, outf;
  logic [3:0] out4;
  logic       sat0, sat1, sat2, sat4, satf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] e0, e1, e2, ef;
  logic [3:0] e4;
  logic       es4;
  logic       v;
  logic [7:0] x;

  always #5 clk = ~clk;

  p_div_pow2_reg #(.SHIFT(2), .CARRYUP(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
    .out_valid(ov0), .rem(rem0), .out(out0), .sat(sat0));

  p_div_pow2_reg #(.SHIFT(2), .CARRYUP(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
    .out_valid(ov1), .rem(rem1), .out(out1), .sat(sat1));

  p_div_pow2_reg #(.SHIFT(2), .CARRYUP(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
    .out_valid(ov2), .rem(rem2), .out(out2), .sat(sat2));

  p_div_pow2_reg #(.SHIFT(2), .CARRYUP(0), .O_PREC(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
    .out_valid(ov4), .rem(rem4), .out(out4), .sat(sat4));

  p_div_pow2_reg #(.SHIFT(2), .CARRYUP(1), .I_DTYPE(1), .I_FRAC(3),
                   .O_DTYPE(1), .O_FRAC(3)) uf (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(din),
    .out_valid(ovf), .rem(remf), .out(outf), .sat(satf));

  // Reference model: floor(x/4), then apply the rounding-mode rule.
  function automatic int ref_div(logic [7:0] xv, int mode);
    int s, fl, d;
    s  = int'($signed(xv));
    fl = s >>> 2;
    d  = s & 3;
    if (mode == 1 && d >= 2) fl = fl + 1;
    if (mode == 2 && d != 0) fl = fl + 1;
    return fl;
  endfunction

  function automatic logic [3:0] ref_out4(logic [7:0] xv);
    int q;
    q = ref_div(xv, 0);
`ifdef P_DIV_POW2_SAT_EN
    if (q > 7)  q = 7;
    if (q < -8) q = -8;
`endif
    return 4'(q);
  endfunction

  function automatic logic ref_sat4(logic [7:0] xv);
    int q;
    q = ref_div(xv, 0);
`ifdef P_DIV_POW2_SAT_EN
    return (q > 7 || q < -8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic apply_stimulus(input logic r, input logic vin, input logic [7:0] xin);
    @(negedge clk);
    reset    = r;
    in_valid = vin;
    din      = xin;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("reset_ov", 32'(ov1), 32'd0);
    check_output("reset_out", 32'(out1), 32'd0);
    check_output("reset_rem", 32'(rem1), 32'd0);
    check_output("reset_sat", 32'(sat1), 32'd0);

    // in=3
    apply_stimulus(1'b0, 1'b1, 8'd3);
    check_output("ov_3", 32'(ov1), 32'd1);
    check_output("m1_out_3", 32'(out1), 32'h01);
    check_output("m1_rem_3", 32'(rem1), 32'd3);
    check_output("m0_out_3", 32'(out0), 32'h00);
    check_output("m2_out_3", 32'(out2), 32'h01);

    // in=-2
    apply_stimulus(1'b0, 1'b1, 8'hFE);
    check_output("m1_out_m2", 32'(out1), 32'h00);
    check_output("m1_rem_m2", 32'(rem1), 32'd2);
    check_output("m0_out_m2", 32'(out0), 32'hFF);
    check_output("m2_out_m2", 32'(out2), 32'h00);

    // in=5
    apply_stimulus(1'b0, 1'b1, 8'd5);
    check_output("m2_out_5", 32'(out2), 32'h02);
    check_output("m2_rem_5", 32'(rem2), 32'd1);
    check_output("m1_out_5", 32'(out1), 32'h01);
    check_output("m0_out_5", 32'(out0), 32'h01);

    // in=127: 4-bit output overflow
    apply_stimulus(1'b0, 1'b1, 8'd127);
`ifdef P_DIV_POW2_SAT_EN
    check_output("o4_out_127", 32'(out4), 32'h7);
    check_output("o4_sat_127", 32'(sat4), 32'd1);
`else
    check_output("o4_out_127", 32'(out4), 32'hF);
    check_output("o4_sat_127", 32'(sat4), 32'd0);
`endif
    check_output("m1_out_127", 32'(out1), 32'h20);
    check_output("m0_out_127", 32'(out0), 32'h1F);

    // FXP 3.5 / 4 = 0.875
    apply_stimulus(1'b0, 1'b1, 8'b00011_100);
    check_output("fxp_out", 32'(outf), 32'b00000_111);
    check_output("fxp_rem", 32'(remf), 32'd0);

    // Idle cycle: results hold, out_valid drops
    apply_stimulus(1'b0, 1'b0, 8'h55);
    check_output("hold_ov", 32'(ov1), 32'd0);
    check_output("hold_out", 32'(out1), 32'h07);
    check_output("hold_rem", 32'(rem1), 32'd0);

    // Reset beats in_valid in the same cycle
    apply_stimulus(1'b1, 1'b1, 8'h55);
    check_output("rst_v_ov", 32'(ov1), 32'd0);
    check_output("rst_v_out", 32'(out1), 32'd0);
    check_output("rst_v_rem", 32'(rem1), 32'd0);

    // First sample after reset: in=-128
    apply_stimulus(1'b0, 1'b1, 8'h80);
    check_output("post_rst_ov", 32'(ov1), 32'd1);
    check_output("m1_out_m128", 32'(out1), 32'hE0);
`ifdef P_DIV_POW2_SAT_EN
    check_output("o4_out_m128", 32'(out4), 32'h8);
    check_output("o4_sat_m128", 32'(sat4), 32'd1);
`else
    check_output("o4_out_m128", 32'(out4), 32'h0);
    check_output("o4_sat_m128", 32'(sat4), 32'd0);
`endif

    e0  = 8'(ref_div(8'h80, 0));
    e1  = 8'(ref_div(8'h80, 1));
    e2  = 8'(ref_div(8'h80, 2));
    ef  = 8'(ref_div(8'h80, 1));
    e4  = ref_out4(8'h80);
    es4 = ref_sat4(8'h80);

    // Random samples with random in_valid
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      apply_stimulus(1'b0, v, x);
      if (v) begin
        e0  = 8'(ref_div(x, 0));
        e1  = 8'(ref_div(x, 1));
        e2  = 8'(ref_div(x, 2));
        ef  = 8'(ref_div(x, 1));
        e4  = ref_out4(x);
        es4 = ref_sat4(x);
      end
      check_output("rnd_ov", 32'(ov1), 32'(v));
      check_output("rnd_m0", 32'(out0), 32'(e0));
      check_output("rnd_m1", 32'(out1), 32'(e1));
      check_output("rnd_m2", 32'(out2), 32'(e2));
      check_output("rnd_fxp", 32'(outf), 32'(ef));
      check_output("rnd_o4", 32'(out4), 32'(e4));
      check_output("rnd_sat4", 32'(sat4), 32'(es4));
      check_output("rnd_sat1", 32'(sat1), 32'd0);
      if (v) check_output("rnd_rem", 32'(rem1), 32'(x[1:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
